// File: rtl/moving_avg_inverse.sv
// moving_avg_inverse
//   Recovers the signed sample stream x[n] from the undivided 4-tap moving
//   sum S[n] = x[n] + x[n-1] + x[n-2] + x[n-3], using the recurrence
//   x[n] = S[n] - S[n-1] + x[n-4]. The history starts at zero, which matches
//   a filter whose delay line also resets to zero, so no priming is needed.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset (highest priority)
//   clr      synchronous history clear (keeps count, drops same-cycle sample)
//   s_valid  s_in carries a valid sum this cycle
//   s_in     signed moving sum S[n], SW bits
//   x_valid  registered one-cycle pulse per accepted sample
//   x_out    signed recovered sample, saturated to DW bits
//   err      sticky out-of-range flag, cleared by reset or clr
//   busy     high whenever the state machine is not IDLE
//   count    accepted samples since reset, wraps at 16 bits
module moving_avg_inverse #(
  parameter int DW = 8,
  parameter int SW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 s_valid,
  input  logic signed [SW-1:0] s_in,
  output logic                 x_valid,
  output logic signed [DW-1:0] x_out,
  output logic                 err,
  output logic                 busy,
  output logic [15:0]          count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Saturation bounds, expressed at the internal SW+2 width.
  localparam int SAT_MAX_I = (32'sd2 ** (DW - 1)) - 32'sd1;
  localparam int SAT_MIN_I = -SAT_MAX_I - 32'sd1;
  localparam logic signed [SW+1:0] SAT_MAX = SAT_MAX_I[SW+1:0];
  localparam logic signed [SW+1:0] SAT_MIN = SAT_MIN_I[SW+1:0];

  state_t                state_r;
  logic signed [SW-1:0]  s_prev_r;
  logic signed [DW-1:0]  h1_r, h2_r, h3_r, h4_r;
  logic signed [DW-1:0]  x_out_r;
  logic                  x_valid_r;
  logic                  err_r;
  logic                  busy_r;
  logic [15:0]           count_r;

  logic signed [SW+1:0]  d_s;
  logic                  ovf_s;
  logic signed [DW-1:0]  sat_s;

  // True when a wide value does not fit the DW signed range.
  function automatic logic is_ovf(input logic signed [SW+1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Clamp a wide value into the DW signed range.
  function automatic logic signed [DW-1:0] sat(input logic signed [SW+1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // Recurrence datapath; SW+2 bits holds the worst case of two sums plus a sample.
  always_comb begin
    d_s   = $signed({{2{s_in[SW-1]}}, s_in})
          - $signed({{2{s_prev_r[SW-1]}}, s_prev_r})
          + $signed({{(SW + 2 - DW){h4_r[DW-1]}}, h4_r});
    ovf_s = is_ovf(d_s);
    sat_s = sat(d_s);
  end

  // State, history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      s_prev_r  <= '0;
      h1_r      <= '0;
      h2_r      <= '0;
      h3_r      <= '0;
      h4_r      <= '0;
      x_out_r   <= '0;
      x_valid_r <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      count_r   <= 16'd0;
    end else if (clr) begin
      // Same as reset but the sample counter survives; a concurrent sample is dropped.
      state_r   <= IDLE;
      s_prev_r  <= '0;
      h1_r      <= '0;
      h2_r      <= '0;
      h3_r      <= '0;
      h4_r      <= '0;
      x_out_r   <= '0;
      x_valid_r <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else if (s_valid) begin
      // The saturated value enters the history so the stream stays deterministic.
      x_out_r   <= sat_s;
      x_valid_r <= 1'b1;
      h1_r      <= sat_s;
      h2_r      <= h1_r;
      h3_r      <= h2_r;
      h4_r      <= h3_r;
      s_prev_r  <= s_in;
      count_r   <= count_r + 16'd1;
      err_r     <= err_r | ovf_s;
      // Any accepted sample leaves IDLE, so busy is known to be high next cycle.
      busy_r    <= 1'b1;
      case (state_r)
        IDLE:    state_r <= ovf_s ? FAULT : RUN;
        RUN:     state_r <= ovf_s ? FAULT : RUN;
        FAULT:   state_r <= FAULT;
        default: state_r <= FAULT;
      endcase
    end else begin
      x_valid_r <= 1'b0;
    end
  end

  assign x_out   = x_out_r;
  assign x_valid = x_valid_r;
  assign err     = err_r;
  assign busy    = busy_r;
  assign count   = count_r;

endmodule

// File: tb/tb_moving_avg_inverse.sv
module tb_moving_avg_inverse;

  logic               clk;
  logic               reset;
  logic               clr;
  logic               s_valid;
  logic signed [11:0] s_in;
  logic               x_valid;
  logic signed [7:0]  x_out;
  logic               err;
  logic               busy;
  logic [15:0]        count;

  int vectors;
  int miscompares;

  moving_avg_inverse #(.DW(8), .SW(12)) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .s_valid (s_valid),
    .s_in    (s_in),
    .x_valid (x_valid),
    .x_out   (x_out),
    .err     (err),
    .busy    (busy),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then wait
  // to the next falling edge so registered outputs are stable for checking.
  task automatic step(input logic v, input int s, input logic c, input logic r);
    s_valid = v;
    s_in    = 12'(s);
    clr     = c;
    reset   = r;
    @(negedge clk);
  endtask

  task automatic feed(input int s, input int exp_x, input string tag);
    step(1'b1, s, 1'b0, 1'b0);
    chk({tag, "_x"}, x_out, exp_x);
    chk({tag, "_v"}, x_valid, 1);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  int xs[$];
  int win[4];
  int ssum;
  int last_x;
  int n_acc;
  int prev_s;
  int rec[$];
  int d;
  int y;
  int s_r;
  logic merr;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; clr = 1'b0; s_valid = 1'b0; s_in = 12'sd0;
    @(negedge clk);

    // Reset while a valid sample is offered.
    step(1'b1, 55, 1'b0, 1'b1);
    step(1'b1, 77, 1'b0, 1'b1);
    chk("rst_x", x_out, 0);
    chk("rst_v", x_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", count, 0);
    step(1'b0, 0, 1'b0, 1'b0);

    // Ramp: sums of 10,20,30,40,50.
    feed(10, 10, "ramp0");
    feed(30, 20, "ramp1");
    feed(60, 30, "ramp2");
    feed(100, 40, "ramp3");
    feed(140, 50, "ramp4");
    chk("ramp_err", err, 0);
    chk("ramp_busy", busy, 1);
    chk("ramp_cnt", count, 5);

    // Negative full scale.
    do_reset();
    feed(-128, -128, "neg0");
    feed(-256, -128, "neg1");
    feed(-384, -128, "neg2");
    feed(-512, -128, "neg3");
    feed(-512, -128, "neg4");
    feed(-512, -128, "neg5");
    chk("neg_err", err, 0);

    // Gapped valid.
    do_reset();
    feed(5, 5, "gap0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 99, 1'b0, 1'b0);
      chk("gap_idle_v", x_valid, 0);
      chk("gap_idle_x", x_out, 5);
    end
    feed(12, 7, "gap1");
    step(1'b0, 0, 1'b0, 1'b0);
    chk("gap_end_v", x_valid, 0);
    chk("gap_cnt", count, 2);

    // Overflow then clr.
    do_reset();
    feed(200, 127, "ovf0");
    chk("ovf_err0", err, 1);
    chk("ovf_busy", busy, 1);
    feed(210, 10, "ovf1");
    chk("ovf_err1", err, 1);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("ovf_clr_err", err, 0);
    chk("ovf_clr_busy", busy, 0);
    chk("ovf_clr_x", x_out, 0);
    chk("ovf_clr_cnt", count, 2);

    // clr mid-stream drops the concurrent sample.
    do_reset();
    feed(10, 10, "clr0");
    feed(30, 20, "clr1");
    feed(60, 30, "clr2");
    step(1'b1, 999, 1'b1, 1'b0);
    chk("clr_drop_v", x_valid, 0);
    chk("clr_drop_cnt", count, 3);
    feed(7, 7, "clr3");
    chk("clr_cnt", count, 4);

    // Reset mid-stream.
    do_reset();
    feed(10, 10, "mrst0");
    feed(30, 20, "mrst1");
    step(1'b1, 60, 1'b0, 1'b1);
    chk("mrst_x", x_out, 0);
    chk("mrst_v", x_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", count, 0);
    feed(4, 4, "mrst2");
    chk("mrst_cnt2", count, 1);

    // Random in-range stream: build sums from known samples, expect the samples back.
    do_reset();
    win = '{0, 0, 0, 0};
    last_x = 0;
    n_acc = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, int'($urandom), 1'b0, 1'b0);
        chk("rnd_idle_v", x_valid, 0);
        chk("rnd_idle_x", x_out, last_x);
      end else begin
        win[3] = win[2]; win[2] = win[1]; win[1] = win[0];
        win[0] = int'($urandom_range(0, 255)) - 128;
        ssum = win[0] + win[1] + win[2] + win[3];
        feed(ssum, win[0], "rnd");
        last_x = win[0];
        n_acc++;
      end
    end
    chk("rnd_err", err, 0);
    chk("rnd_cnt", count, n_acc);

    // Random wide sums including out-of-range results: reference recurrence
    // with saturated history and a sticky error flag.
    do_reset();
    prev_s = 0;
    rec = {0, 0, 0, 0};
    merr = 1'b0;
    for (int i = 0; i < 120; i++) begin
      s_r = int'($urandom_range(0, 1400)) - 700;
      d = s_r - prev_s + rec[3];
      y = (d > 127) ? 127 : ((d < -128) ? -128 : d);
      if (d > 127 || d < -128) merr = 1'b1;
      rec.push_front(y);
      void'(rec.pop_back());
      prev_s = s_r;
      feed(s_r, y, "wide");
      chk("wide_err", err, merr);
      chk("wide_busy", busy, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/moving_avg_inverse.md
Name: moving_avg_inverse

Overview:
- Reconstructs the original signed 8-bit sample stream x[n] from the undivided 4-tap moving-sum stream S[n] = x[n]+x[n-1]+x[n-2]+x[n-3].
- Sits at the far end of a moving-average link. It is used as the decoder for the filter's pre-shift sum, and in loopback self-checks of the averaging path.
- Recurrence: x[n] = S[n] - S[n-1] + x[n-4]. The previous sum and the last 4 recovered samples are held in registers.
- Includes a valid-gated input, a registered output, a fault state machine, and a synchronous history clear.

Parameters:
- DW, 8, sample width of recovered x (signed).
- SW, 12, sum input width (signed); must be at least DW+2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- clr  input  1  synchronous history clear; same effect as reset except the sample counter
- s_valid  input  1  S[n] on s_in is valid this cycle
- s_in  input  SW  signed moving sum S[n]
- x_valid  output  1  x_out valid; registered 1-cycle pulse per accepted sample
- x_out  output  DW  signed recovered sample, saturated
- err  output  1  sticky: a recovered value exceeded the DW signed range
- busy  output  1  high when state != IDLE
- count  output  16  accepted samples since reset; wraps at 0xFFFF→0

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled only on that edge.
- Reset (synchronous, active-high, priority over everything):
  - s_prev, h1..h4 = 0
  - x_out = 0, x_valid = 0, err = 0, count = 0
  - state = IDLE
- clr (next priority):
  - clears s_prev, h1..h4, x_out, x_valid and err; state = IDLE
  - count is kept
  - any s_valid in the same cycle is dropped and not counted
- Zero history models a filter whose delay line resets to 0, so recovery is exact from the first sample; no priming cycles.
- Datapath, on each cycle with s_valid=1 and no reset or clr:
  - d = s_in - s_prev + h4, computed at SW+2 signed bits (no internal overflow possible).
  - x_out <= sat(d) to [-2^(DW-1), 2^(DW-1)-1]; x_valid <= 1.
  - h4 <= h3, h3 <= h2, h2 <= h1, h1 <= sat(d); s_prev <= s_in; count <= count+1.
- Latency: result appears on x_out/x_valid exactly 1 cycle after s_valid.
- If s_valid=0: x_valid <= 0; x_out, s_prev, history and count hold.
- Saturated values enter the history, so after a fault the stream stays deterministic but is not exact.
- States:
  - IDLE: no sample since reset/clr. Valid sample in range → RUN; out of range → FAULT.
  - RUN: out-of-range sample → FAULT; otherwise stay.
  - FAULT: err=1. Keeps processing samples. Leaves only via reset or clr → IDLE.
- err is set on the same edge that registers the saturated x_out. It stays high until reset or clr.
- No backpressure: one sample per cycle, and the block is always ready.
- Back-to-back valid cycles are supported at full rate.

Test Plan:
- Reset, then s_valid held with s_in = 10,30,60,100,140 → x_out 10,20,30,40,50, each one cycle after input. err=0, state RUN, count=5.
- Negative full-scale: s_in = -128,-256,-384,-512,-512,-512 → x_out -128 every valid cycle. No err.
- Gapped valid: s_in=5 (valid), 3 idle cycles, s_in=12 (valid) → x_out 5, then 7. x_valid high for exactly 2 cycles. Values hold during the gap. count=2.
- Overflow: first s_in=200 → x_out=127, err=1, state FAULT. Next s_in=210 → d=210-200+0=10, x_out=10, err stays 1. Then clr → err=0, busy=0, count unchanged.
- clr mid-stream: feed 10,30,60, then clr with s_valid=1, s_in=999 → that sample is dropped. Next s_in=7 → x_out=7 (history zeroed).
- Reset asserted mid-stream with s_valid=1 → next cycle all outputs 0 and state IDLE. Deasserted with s_in=4 → x_out=4.
